snn_weight_store: RTL
=====================

Name: snn_weight_store

Overview:
- Responder end of the SNN core's weight read and write-back channels.
- Holds 2**ADDR_W packed signed-nibble weight words and serves read requests with a fixed latency.
- Commits write-backs and acknowledges them one cycle later.
- A host configuration port preloads and reads back weights between inference runs; sits beside the Multilayer core inside the top wrapper.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W words.
- DW, 8, word width; packs two signed 4-bit weights {hi,lo}.
- RD_LAT, 1, cycles from sampled w_req to w_valid; legal range 1..7.
- INIT_WORD, 8'h11, reset value of every word (both weights = +1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_req  in  1  read request, single-cycle pulse.
- w_addr  in  ADDR_W  read address, valid with w_req.
- w_valid  out  1  read response pulse, one cycle.
- w_data  out  DW  read data, valid with w_valid.
- wb_req  in  1  write-back request, single-cycle pulse.
- wb_addr  in  ADDR_W  write-back address.
- wb_wdata  in  DW  write-back data.
- wb_ack  out  1  write-back acknowledge pulse.
- cfg_we  in  1  host write strobe.
- cfg_addr  in  ADDR_W  host address (write and readback).
- cfg_wdata  in  DW  host write data.
- cfg_rdata  out  DW  registered readback of mem[cfg_addr].
- cfg_drop  out  1  pulse: host write lost to a same-cycle, same-address write-back.
- ovr_err  out  1  sticky: request arrived while the same channel was busy.
- err_clr  in  1  synchronous clear of ovr_err.

Behaviour:
- One clock domain; reset is asynchronous and active-low on rst_n.
- Reset values:
  - All memory words = INIT_WORD.
  - w_valid = 0, w_data = 0, wb_ack = 0.
  - cfg_rdata = 0, cfg_drop = 0, ovr_err = 0.
  - Read FSM = R_IDLE; latency counter = 0.
- Reset asserted mid-transaction aborts it; no w_valid or wb_ack follows.

Read FSM (R_IDLE, R_WAIT, R_RESP):
- R_IDLE: on w_req, snapshot mem[w_addr] into the data register.
  - RD_LAT = 1: go to R_RESP.
  - RD_LAT > 1: load counter = RD_LAT-1 and go to R_WAIT.
- R_WAIT: decrement the counter each cycle; go to R_RESP on the cycle it reaches 1.
- R_RESP: drive w_valid = 1 and w_data = snapshot for exactly one cycle, then return to R_IDLE.
- w_data returns to 0 whenever w_valid = 0.
- Timing: w_valid rises RD_LAT cycles after the edge that sampled w_req. With RD_LAT = 1, w_req sampled at edge N gives w_valid high N+1 to N+2.
- The snapshot is taken at the request edge:
  - A write-back committed on that same edge to the same address is NOT seen (old data returned).
  - Writes committed later are not seen either.
- w_req outside R_IDLE is ignored and sets ovr_err.
- A w_req may be accepted in the cycle right after R_RESP (back-to-back reads allowed).

Write-back:
- wb_req sampled at edge N commits mem[wb_addr] = wb_wdata at edge N.
- wb_ack is high for one cycle, N+1 to N+2.
- wb_req while wb_ack = 1 is ignored and sets ovr_err.
- Reads and writes are independent; both may be in flight at once.

Host port:
- cfg_we commits mem[cfg_addr] = cfg_wdata at the sampling edge.
- Same edge, same address as an accepted wb_req: the write-back wins, the host write is discarded, and cfg_drop pulses one cycle later.
- Same edge, different addresses: both commit.
- cfg_rdata is loaded every cycle with mem[cfg_addr] as it stood before that edge's writes.

Error flag:
- ovr_err is set by any ignored request.
- err_clr clears it, but a set in the same cycle wins over the clear.

Arithmetic: none; data is stored opaquely and never sign-extended.

Decomposition:
- Shared package snn_mem_pkg:
  - W12_ADDR = 4'h0, W34_ADDR = 4'h1 (shared with the Multilayer core).
  - rd_state_t enum.
  - Default INIT_WORD.
- One sub-module, snn_weight_regfile:
  - DEPTH x DW flops with asynchronous reset to INIT_WORD.
  - Two write ports with fixed priority (port 0 = write-back).
  - Two combinational read ports.
- The handshake FSM, counter and error logic stay in snn_weight_store.

Test Plan:
- Reset then cfg_addr sweep 0..15 -> cfg_rdata = 8'h11 for every word; all outputs 0.
- RD_LAT=1: cfg write 0xA3 to addr 1, then w_req addr 1 at edge N -> w_valid high only in cycle N+1, w_data = 8'hA3. Repeat with RD_LAT=3 -> w_valid in cycle N+3 only.
- wb_req addr 0 data 8'h2F -> wb_ack one cycle later. A following w_req to addr 0 returns 8'h2F. w_req and wb_req to addr 0 on the same edge -> read returns the old value.
- cfg_we addr 5 data 0x77 on the same edge as wb_req addr 5 data 0x9C -> mem[5] = 0x9C, cfg_drop pulses once. Different addresses -> both written, no cfg_drop.
- RD_LAT=3: second w_req during R_WAIT -> ignored, exactly one w_valid, ovr_err = 1. err_clr -> ovr_err = 0. err_clr on the same edge as a new overrun -> ovr_err stays 1.
- rst_n pulsed low during R_WAIT -> no w_valid afterwards, memory back to 8'h11, FSM accepts a fresh w_req.

Source files
------------

// File: rtl/snn_mem_pkg.sv
// rtl/snn_mem_pkg.sv - shared weight-memory constants and read FSM state type
package snn_mem_pkg;

    localparam logic [3:0] W12_ADDR          = 4'h0;
    localparam logic [3:0] W34_ADDR          = 4'h1;
    localparam logic [7:0] INIT_WORD_DEFAULT = 8'h11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

endpackage

// File: rtl/snn_weight_regfile.sv
// rtl/snn_weight_regfile.sv - weight flop array, two prioritised write ports, two async read ports
module snn_weight_regfile
    import snn_mem_pkg::*;
#(
    parameter int              ADDR_W    = 4,
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   INIT_WORD = INIT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DW-1:0]     wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DW-1:0]     rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DW-1:0]     rdata1
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DW-1:0] mem [DEPTH];

    // Port 0 is written last so it overrides port 1 on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_WORD;
            end
        end else begin
            if (we1) mem[waddr1] <= wdata1;
            if (we0) mem[waddr0] <= wdata0;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/snn_weight_store.sv
// rtl/snn_weight_store.sv - weight read/write-back responder with host preload port
module snn_weight_store
    import snn_mem_pkg::*;
#(
    parameter int            ADDR_W    = 4,
    parameter int            DW        = 8,
    parameter int            RD_LAT    = 1,
    parameter logic [DW-1:0] INIT_WORD = INIT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic [DW-1:0]     w_data,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DW-1:0]     wb_wdata,
    output logic              wb_ack,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DW-1:0]     cfg_wdata,
    output logic [DW-1:0]     cfg_rdata,
    output logic              cfg_drop,
    output logic              ovr_err,
    input  logic              err_clr
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    rd_state_t     rd_state, rd_next;
    logic [2:0]    cnt, cnt_next;
    logic [DW-1:0] snap;
    logic [DW-1:0] rd_word, cfg_word;

    logic rd_accept, rd_ovr, wb_accept, wb_ovr, host_drop, host_we;

    assign rd_accept = w_req & (rd_state == R_IDLE);
    assign rd_ovr    = w_req & (rd_state != R_IDLE);
    assign wb_accept = wb_req & ~wb_ack;
    assign wb_ovr    = wb_req & wb_ack;
    assign host_drop = cfg_we & wb_accept & (cfg_addr == wb_addr);
    assign host_we   = cfg_we & ~host_drop;

    snn_weight_regfile #(
        .ADDR_W    (ADDR_W),
        .DW        (DW),
        .INIT_WORD (INIT_WORD)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we0    (wb_accept),
        .waddr0 (wb_addr),
        .wdata0 (wb_wdata),
        .we1    (host_we),
        .waddr1 (cfg_addr),
        .wdata1 (cfg_wdata),
        .raddr0 (w_addr),
        .rdata0 (rd_word),
        .raddr1 (cfg_addr),
        .rdata1 (cfg_word)
    );

    // Snapshot reads the pre-edge array, so a same-edge write-back is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            cnt      <= '0;
            snap     <= '0;
        end else begin
            rd_state <= rd_next;
            cnt      <= cnt_next;
            if (rd_accept) snap <= rd_word;
        end
    end

    always_comb begin
        rd_next  = rd_state;
        cnt_next = cnt;
        case (rd_state)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_next  = (RD_LAT == 1) ? R_RESP : R_WAIT;
                    cnt_next = LAT_LOAD;
                end
            end
            R_WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) rd_next = R_RESP;
            end
            R_RESP:  rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_valid = (rd_state == R_RESP);
        w_data  = w_valid ? snap : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack    <= 1'b0;
            cfg_drop  <= 1'b0;
            cfg_rdata <= '0;
            ovr_err   <= 1'b0;
        end else begin
            wb_ack    <= wb_accept;
            cfg_drop  <= host_drop;
            cfg_rdata <= cfg_word;
            if (rd_ovr | wb_ovr) ovr_err <= 1'b1;
            else if (err_clr)    ovr_err <= 1'b0;
        end
    end

endmodule
